// File: rtl/aes_round_ctrl_if.sv
// Bundle between the AES round sequencer and its host, round core, S-box unit and key store.
interface aes_round_ctrl_if;
  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;

  logic             start;
  logic [BLK_W-1:0] din;
  logic             busy;
  logic             done;
  logic [BLK_W-1:0] dout;
  logic             err;
  logic [BLK_W-1:0] core_din;
  logic [1:0]       core_sel;
  logic [BLK_W-1:0] core_dout;
  logic             sb_req;
  logic [BLK_W-1:0] sb_din;
  logic             sb_ack;
  logic [BLK_W-1:0] sb_dout;
  logic             rk_req;
  logic [RND_W-1:0] rk_idx;
  logic             rk_valid;
  logic [BLK_W-1:0] rk;

  modport master (
    input  start, din, core_dout, sb_ack, sb_dout, rk_valid, rk,
    output busy, done, dout, err, core_din, core_sel, sb_req, sb_din, rk_req, rk_idx
  );

  modport slave (
    output start, din, core_dout, sb_ack, sb_dout, rk_valid, rk,
    input  busy, done, dout, err, core_din, core_sel, sb_req, sb_din, rk_req, rk_idx
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: state register, round counter and SubBytes/round-key handshakes.
// Optional handshake timeout with err pulse when AES_RCTRL_TIMEOUT_EN is defined.
module aes_round_ctrl #(
  parameter int unsigned NR  = 10,
  parameter int unsigned TMO = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_ctrl_if.master bus
);
  localparam int unsigned BLK_W = 128;
  localparam int unsigned RND_W = 4;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);
  localparam logic [1:0] SEL_INIT  = 2'b00;
  localparam logic [1:0] SEL_MID   = 2'b01;
  localparam logic [1:0] SEL_FINAL = 2'b10;

  if (NR < 1 || NR > 15 || TMO < 1) begin : g_param_chk
    $error("aes_round_ctrl: NR must be 1..15 and TMO must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_KEY  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [BLK_W-1:0] st_q, st_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic             tmo_c;

  // State, block and round registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
    end
  end

  // Next state; a timeout abandons the block but leaves st untouched
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          st_d    = bus.din;
          rnd_d   = '0;
          state_d = ST_KEY;
        end
      end
      ST_SUB: begin
        if (tmo_c) begin
          state_d = ST_IDLE;
        end else if (bus.sb_ack) begin
          st_d    = bus.sb_dout;
          state_d = ST_KEY;
        end
      end
      ST_KEY: begin
        if (tmo_c) begin
          state_d = ST_IDLE;
        end else if (bus.rk_valid) begin
          st_d = bus.core_dout ^ bus.rk;
          if (rnd_q == LAST_RND) begin
            state_d = ST_DONE;
          end else begin
            rnd_d   = rnd_q + RND_W'(1);
            state_d = ST_SUB;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore decode of state/round registers; err is the only same-cycle term
  always_comb begin
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.sb_req = 1'b0;
    bus.rk_req = 1'b0;
    case (state_q)
      ST_SUB:  bus.sb_req = 1'b1;
      ST_KEY:  bus.rk_req = 1'b1;
      ST_DONE: bus.done   = 1'b1;
      default: ;
    endcase
    bus.busy     = (state_q != ST_IDLE);
    bus.err      = tmo_c;
    bus.rk_idx   = rnd_q;
    bus.dout     = st_q;
    bus.core_din = st_q;
    bus.sb_din   = st_q;
    if (rnd_q == '0) begin
      bus.core_sel = SEL_INIT;
    end else if (rnd_q == LAST_RND) begin
      bus.core_sel = SEL_FINAL;
    end else begin
      bus.core_sel = SEL_MID;
    end
  end

`ifdef AES_RCTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;

  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             waiting_c;

  always_comb begin
    waiting_c = ((state_q == ST_SUB) && !bus.sb_ack) ||
                ((state_q == ST_KEY) && !bus.rk_valid);
    tmo_c     = waiting_c && (wcnt_q == CNT_W'(TMO));
  end

  // Wait counter restarts on every state change so each request gets a full budget
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d != state_q) begin
      wcnt_d = '0;
    end else if (waiting_c) begin
      wcnt_d = wcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`else
  assign tmo_c = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl with behavioural round core, S-box unit and key store.
module tb_aes_round_ctrl;
  localparam int NR = 10;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus_if ();

  aes_round_ctrl #(.NR(NR), .TMO(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int last_start = 0;
  int ksel = 0;
  logic new_blk;
  int sb_stall [16];
  int rk_stall [16];
  int sb_n, rk_n, sb_wait, rk_wait;
  logic [127:0] rkeys [2][11];
  logic [127:0] exp_ct_q [$];
  int           exp_cyc_q [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq  = a;
    logic [7:0] inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  task automatic expand_key(input int ks, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rkeys[ks][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- environment: core, S-box unit, key store ----------------
  always_comb begin
    case (bus_if.core_sel)
      2'b00:   bus_if.core_dout = bus_if.core_din;
      2'b01:   bus_if.core_dout = mix_columns(shift_rows(bus_if.core_din));
      2'b10:   bus_if.core_dout = shift_rows(bus_if.core_din);
      default: bus_if.core_dout = '0;
    endcase
    bus_if.sb_dout  = sub_bytes(bus_if.sb_din);
    bus_if.sb_ack   = bus_if.sb_req && (sb_wait >= sb_stall[(sb_n + 1) % 16]);
    bus_if.rk       = rkeys[ksel][(bus_if.rk_idx > 4'd10) ? 0 : int'(bus_if.rk_idx)];
    bus_if.rk_valid = bus_if.rk_req && (rk_wait >= rk_stall[rk_n % 16]);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || new_blk) begin
      sb_n <= 0; rk_n <= 0; sb_wait <= 0; rk_wait <= 0;
    end else begin
      if (bus_if.sb_req && bus_if.sb_ack) begin sb_n <= sb_n + 1; sb_wait <= 0; end
      else if (bus_if.sb_req) sb_wait <= sb_wait + 1;
      else sb_wait <= 0;
      if (bus_if.rk_req && bus_if.rk_valid) begin rk_n <= rk_n + 1; rk_wait <= 0; end
      else if (bus_if.rk_req) rk_wait <= rk_wait + 1;
      else rk_wait <= 0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor / scoreboard ----------------
  logic         prev_sb_w, prev_rk_w, prev_err;
  logic [127:0] prev_sb_din;
  logic [3:0]   prev_rk_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sb_w <= 1'b0; prev_rk_w <= 1'b0; prev_err <= 1'b0;
    end else begin
      check("req_excl", 128'(bus_if.sb_req & bus_if.rk_req), 128'(0));
      if (prev_sb_w && !prev_err) begin
        check("sb_req_hold", 128'(bus_if.sb_req), 128'(1));
        check("sb_din_hold", bus_if.sb_din, prev_sb_din);
      end
      if (prev_rk_w && !prev_err) begin
        check("rk_req_hold", 128'(bus_if.rk_req), 128'(1));
        check("rk_idx_hold", 128'(bus_if.rk_idx), 128'(prev_rk_idx));
      end
      if (bus_if.rk_req && bus_if.rk_valid) begin
        check("rk_idx", 128'(bus_if.rk_idx), 128'(rk_n));
        check("core_sel", 128'(bus_if.core_sel),
              128'((rk_n == 0) ? 2'b00 : (rk_n == NR) ? 2'b10 : 2'b01));
      end
      if (bus_if.done) begin
        done_cnt <= done_cnt + 1;
        if (exp_ct_q.size() == 0) begin
          check("spurious_done", 128'(bus_if.done), 128'(0));
        end else begin
          check("dout", bus_if.dout, exp_ct_q[0]);
          check("done_cyc", 128'(cyc), 128'(exp_cyc_q[0]));
          exp_ct_q.delete(0);
          exp_cyc_q.delete(0);
        end
      end
      if (bus_if.err) err_cnt <= err_cnt + 1;
      prev_sb_w   <= bus_if.sb_req && !bus_if.sb_ack;
      prev_rk_w   <= bus_if.rk_req && !bus_if.rk_valid;
      prev_err    <= bus_if.err;
      prev_sb_din <= bus_if.sb_din;
      prev_rk_idx <= bus_if.rk_idx;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int stall_sum();
    int s = 0;
    for (int i = 1; i <= NR; i++) s += sb_stall[i];
    for (int i = 0; i <= NR; i++) s += rk_stall[i];
    return s;
  endfunction

  task automatic set_stalls(input int max_st);
    for (int i = 0; i < 16; i++) begin
      sb_stall[i] = $urandom_range(0, max_st);
      rk_stall[i] = $urandom_range(0, max_st);
    end
  endtask

  task automatic start_block(input logic [127:0] pt, input int ks, input logic [127:0] ct,
                             input bit expect_done);
    ksel           = ks;
    bus_if.din     = pt;
    bus_if.start   = 1'b1;
    new_blk        = 1'b1;
    last_start     = cyc;
    if (expect_done) begin
      exp_ct_q.push_back(ct);
      exp_cyc_q.push_back(cyc + 2 * NR + 2 + stall_sum());
    end
    @(negedge clk);
    bus_if.start = 1'b0;
    new_blk      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0  = done_cnt;
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin got = 1'b1; break; end
    end
    check({tag, "_wait"}, 128'(got), 128'(1));
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 128'(bus_if.busy), 128'(0));
    check({tag, "_done"}, 128'(bus_if.done), 128'(0));
    check({tag, "_err"}, 128'(bus_if.err), 128'(0));
    check({tag, "_sbreq"}, 128'(bus_if.sb_req), 128'(0));
    check({tag, "_rkreq"}, 128'(bus_if.rk_req), 128'(0));
    check({tag, "_dout"}, bus_if.dout, 128'(0));
    check({tag, "_sel"}, 128'(bus_if.core_sel), 128'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit found;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.din   = '0;
    new_blk      = 1'b0;
    set_stalls(0);
    expand_key(0, KEY_A);
    expand_key(1, KEY_B);
    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 vector, zero-wait handshakes
    start_block(PT_A, 0, CT_A, 1);
    wait_done("fips", 60);

    // Random 0..5 cycle stalls, both vectors
    set_stalls(5);
    start_block(PT_A, 0, CT_A, 1);
    wait_done("stall_a", 200);
    set_stalls(5);
    start_block(PT_B, 1, CT_B, 1);
    wait_done("stall_b", 200);

    // start pulses while busy and in DONE are ignored; next IDLE cycle accepts
    set_stalls(0);
    start_block(PT_A, 0, CT_A, 1);
    c = last_start;
    while (cyc < c + 23) begin
      bus_if.din   = ~PT_A;
      bus_if.start = (cyc == c + 5) || (cyc == c + 22);
      @(negedge clk);
    end
    #1;
    check("dout_hold", bus_if.dout, CT_A);
    start_block(PT_B, 1, CT_B, 1);
    check("accept_cyc", 128'(last_start), 128'(c + 23));
    wait_done("restart", 60);

    // Asynchronous reset during round 5 discards the block
    start_block(PT_A, 0, CT_A, 0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (bus_if.rk_req && bus_if.rk_idx == 4'd5) begin found = 1'b1; break; end
    end
    check("rst_find", 128'(found), 128'(1));
    #2 rst_n = 1'b0;
    #1 check_quiet("midrst");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    set_stalls(5);
    start_block(PT_B, 1, CT_B, 1);
    wait_done("after_rst", 200);

    // Withheld SubBytes ack in round 3
    set_stalls(0);
`ifdef AES_RCTRL_TIMEOUT_EN
    sb_stall[3] = 5000;
    start_block(PT_A, 0, CT_A, 0);
    c = last_start;
    while (cyc < c + 6 + 255) @(negedge clk);
    #1;
    check("tmo_err", 128'(bus_if.err), 128'(1));
    @(negedge clk);
    #1;
    check("tmo_busy", 128'(bus_if.busy), 128'(0));
    check("tmo_sbreq", 128'(bus_if.sb_req), 128'(0));
    repeat (10) @(negedge clk);
    check("err_count", 128'(err_cnt), 128'(1));
`else
    sb_stall[3] = 1005;
    start_block(PT_A, 0, CT_A, 1);
    c = last_start;
    while (cyc < c + 6 + 1000) @(negedge clk);
    #1;
    check("hang_sbreq", 128'(bus_if.sb_req), 128'(1));
    check("hang_busy", 128'(bus_if.busy), 128'(1));
    check("hang_err", 128'(err_cnt), 128'(0));
    wait_done("hang_release", 100);
    check("err_count", 128'(err_cnt), 128'(0));
`endif
    set_stalls(0);
    repeat (2) @(negedge clk);
    check("sb_left", 128'(exp_ct_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative round sequencer for the combinational AES round datapath (ShiftRows/MixColumns core with `sel` mode input). It holds the 128-bit state register and walks one block through initial AddRoundKey, NR-1 full rounds and the final round. It drives the core's `din`/`sel` and XORs the round key onto the core output. SubBytes is external (CIM S-box unit) and round keys come from an external key store, both reached through req/ack handshakes.

## Interface

Parameters:
- `NR`, 10: number of rounds (10/12/14 for AES-128/192/256); `rk_idx` covers 0..NR.
- `TMO`, 255: handshake wait limit in cycles (used only with `AES_RCTRL_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a block; sampled only in IDLE.
- `din`  in  128  plaintext; captured with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted through DONE.
- `done`  out  1  one-cycle pulse; `dout` valid.
- `dout`  out  128  state register; holds the ciphertext until the next `start`.
- `err`  out  1  one-cycle pulse on handshake timeout; constant 0 without the macro.
- `core_din`  out  128  equals the state register.
- `core_sel`  out  2  00 for round 0, 10 for round NR, 01 otherwise.
- `core_dout`  in  128  combinational core result.
- `sb_req`  out  1  SubBytes request.
- `sb_din`  out  128  equals the state register.
- `sb_ack`  in  1  `sb_dout` valid this cycle.
- `sb_dout`  in  128  substituted state.
- `rk_req`  out  1  round-key request.
- `rk_idx`  out  4  round index 0..NR.
- `rk_valid`  in  1  `rk` valid this cycle.
- `rk`  in  128  round key `rk_idx`.

## Operation

- State register `st`, round counter `rnd` (4 bits).
- **IDLE**
  - If `start`: `st<=din`, `rnd<=0`, go to KEY.
- **SUB**
  - `sb_req=1`.
  - On `sb_ack`: `st<=sb_dout`, go to KEY.
- **KEY**
  - `rk_req=1`, `rk_idx=rnd`.
  - On `rk_valid`: `st<=core_dout^rk`.
  - If `rnd==NR`, go to DONE. Otherwise `rnd<=rnd+1` and go to SUB.
- **DONE**
  - `done=1`, then go to IDLE.
- Request and data stability:
  - `sb_req` and `rk_req` stay high and stable, with `sb_din`/`rk_idx` unchanged, until acknowledged.
  - Each request drops the cycle after its ack.
  - `sb_req` and `rk_req` are never both high.
- Ignored inputs:
  - `sb_ack`/`rk_valid` are ignored outside SUB/KEY respectively.
  - `start` is ignored when not in IDLE. No queueing.
- `core_sel` decodes from `rnd` in all states (00 when `rnd==0`).
- Reset values, all while `rst_n=0` regardless of state:
  - `st`, `rnd`, `dout` = 0.
  - `busy`, `done`, `err`, `sb_req`, `rk_req` = 0.
  - `core_sel` = 00; FSM = IDLE.
- Reset mid-block discards the block. No `done`.

## Timing

- `start` sampled at edge E0 → KEY in cycle 1. KEY round r falls in cycle 2r+1 with zero-wait handshakes.
- `done` is high in cycle 2·NR+2, which is cycle 22 for NR=10.
- Each wait cycle on `sb_ack`/`rk_valid` adds exactly one cycle.
- Combinational `sb_ack`/`rk_valid` in the same cycle as the request is legal and gives zero wait.
- `dout` changes only on the state-register update edges; it equals the ciphertext from the `done` cycle until the next accepted `start`.
- `start` asserted in the DONE cycle is ignored. The earliest accepted `start` is in the following IDLE cycle.

## Configuration

- `AES_RCTRL_TIMEOUT_EN` defined:
  - An 8-bit-or-wider wait counter clears on entry to SUB/KEY and increments each unacknowledged cycle.
  - When it reaches `TMO`, that cycle pulses `err`, drops the request, and returns to IDLE. `st` is left as is and there is no `done`.
- Undefined:
  - No counter; the FSM waits indefinitely; `err` is tied to 0.

## Test plan

- **FIPS-197 vector:** pt 00112233445566778899aabbccddeeff, key 000102…0f, zero-wait S-box/key models → `done` at cycle 22, `dout`=69c4e0d86a7b0430d8cdb78070b4c55a, `core_sel` sequence 00,01×9,10.
- **Random stalls:** same vector with 0–5 cycle stalls on `sb_ack`/`rk_valid` → same `dout`; `done` cycle = 22 + total stall cycles; requests stable while waiting; `rk_idx` sequence 0..10.
- **Start while busy:** `start` pulsed at cycles 5 and 22 with a different `din` → ignored; `dout` unchanged; a second `start` at cycle 23 runs normally.
- **Reset mid-block:** `rst_n` low asynchronously during round 5 → all outputs 0 immediately, no `done`; a new block afterwards completes correctly.
- **Timeout (macro on, TMO=255):** withhold `sb_ack` in round 3 → `err` pulses 255 cycles after SUB entry, `busy`=0 next cycle, no `done`.
- **Timeout (macro off):** same stimulus → still waiting after 1000 cycles; `err`=0; releasing `sb_ack` completes with the correct ciphertext.
